reflex_gate_equiv_monitor: RTL
==============================

Name: reflex_gate_equiv_monitor

Overview:
Multi-channel, latency-aligned equivalence monitor for the reflex kernel gate. It compares NCH hardware gate verdicts against bit-exact golden verdicts, after delaying the golden results by the DUT pipeline latency. It keeps per-channel sticky flags, saturating counters and a first-failure snapshot. It sits beside the gate array in sim/FPGA-debug builds and is readable by the debug register block.

Parameters:
NCH, 4, number of gate channels compared in parallel (1..32)
LAT, 2, DUT latency in cycles from in_valid to hw_valid (0..8)
CNT_W, 16, width of the saturating check and mismatch counters
TAG_W, 16, width of the saturating cycle-stamp counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
enable  in  1  monitor on; deassert returns to IDLE
clear  in  1  one-cycle pulse: clears counters, sticky flags and snapshot, re-enters WARMUP
in_valid  in  1  golden inputs valid this cycle
trusted_sw  in  NCH  golden verdicts, sampled when in_valid=1
hw_valid  in  1  DUT verdicts valid this cycle
trusted_hw  in  NCH  DUT verdicts, sampled when hw_valid=1
state  out  2  0=IDLE 1=WARMUP 2=CHECK 3=FAIL
mismatch_pulse  out  1  registered one-cycle pulse per failing compare
mismatch_sticky  out  NCH  per-channel sticky mismatch
proto_err  out  1  sticky; hw_valid and expected-valid disagreed
check_cnt  out  CNT_W  compares performed, saturating
mismatch_cnt  out  CNT_W  failing compares, saturating
first_fail_vec  out  NCH  XOR vector of the first failing compare
first_fail_cycle  out  TAG_W  cycle stamp of the first failure

Behaviour:
- Reset: all outputs 0, state=IDLE, delay line valids 0, cycle stamp 0.
- Delay line: LAT stages of {valid, NCH verdicts}. Stage 0 loads {in_valid, trusted_sw} every cycle. exp_valid/exp_vec is the stage LAT-1 output. With LAT=0, exp = the current inputs.
- Compare cycle t: active when state is CHECK or FAIL and exp_valid=1 and hw_valid=1. diff = exp_vec ^ trusted_hw.
- Compare result updates registers at edge t+1: check_cnt +1; if diff!=0 then mismatch_cnt +1, mismatch_pulse=1 for one cycle, mismatch_sticky |= diff.
- Both counters saturate at all-ones and never wrap.
- exp_valid != hw_valid while in CHECK or FAIL: proto_err sets; no compare happens and no counter changes.
- Cycle stamp: cleared on entry to CHECK, +1 per cycle in CHECK/FAIL, saturating.
- First failure, in CHECK only: capture first_fail_vec=diff and first_fail_cycle=stamp at cycle t; go to FAIL.
- FAIL: snapshot frozen; counters and sticky flags keep updating.
- FSM transitions:
  - IDLE -> WARMUP when enable=1.
  - WARMUP: counts LAT cycles, no compares, delay line fills, then -> CHECK. LAT=0 goes IDLE -> CHECK directly.
  - Any state -> IDLE when enable=0: delay line valids cleared; counters, flags and snapshot retained.
- clear:
  - With enable=1: zero counters, sticky, proto_err and snapshot; -> WARMUP (CHECK if LAT=0); delay line valids cleared.
  - With enable=0: zero the same registers; stay IDLE.
- Precedence, highest first: rst_n, enable=0, clear, compare. A mismatch coinciding with clear is discarded.
- Reset mid-operation: full reset; in-flight delay line entries are dropped.

Optional Feature:
REFLEX_EQUIV_ASSERT_EN
- Defined: a simulation-only immediate assertion fires $error("REFLEX-GATE mismatch ch=%0d @%0t") for each set bit of diff. A second assertion fires on proto_err rising.
- Undefined: no assertions are compiled; registered behaviour is identical.

Test Plan:
- LAT=2, NCH=4, enable=1, matching streams for 20 valid inputs -> check_cnt=20, mismatch_cnt=0, state=CHECK, proto_err=0.
- Flip trusted_hw[2] on the 5th compare (stamp=6) -> mismatch_pulse one cycle, mismatch_sticky=4'b0100, first_fail_vec=4'b0100, first_fail_cycle=6, state=FAIL.
- Second mismatch on ch0 after the first -> mismatch_sticky=4'b0101, mismatch_cnt=2, snapshot unchanged.
- hw_valid asserted one cycle early (exp_valid=0) -> proto_err=1, check_cnt unchanged.
- CNT_W=4, 20 mismatching compares -> mismatch_cnt=15 and held.
- clear in the same cycle as a mismatch -> all counters 0, sticky 0, state=WARMUP then CHECK after 2 cycles; LAT=0 build -> IDLE goes directly to CHECK.

Source files
------------

// File: rtl/reflex_gate_equiv_monitor.sv
// reflex_gate_equiv_monitor
// Latency-aligned equivalence monitor for the reflex kernel gate array.
// Golden verdicts are delayed by LAT cycles and compared against the
// hardware verdicts on NCH channels. The monitor keeps saturating
// check/mismatch counters, per-channel sticky flags and a snapshot of
// the first failing compare.
//
// Optional build macro: REFLEX_EQUIV_ASSERT_EN
//   defined   -> simulation-only assertions on per-channel mismatches and
//                on proto_err rising
//   undefined -> no assertions; registered behaviour is identical

module reflex_gate_equiv_monitor #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned LAT   = 2,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned TAG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [NCH-1:0]   trusted_sw,
    input  logic             hw_valid,
    input  logic [NCH-1:0]   trusted_hw,
    output logic [1:0]       state,
    output logic             mismatch_pulse,
    output logic [NCH-1:0]   mismatch_sticky,
    output logic             proto_err,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [NCH-1:0]   first_fail_vec,
    output logic [TAG_W-1:0] first_fail_cycle
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FAIL   = 2'd3
    } state_t;

    // Last warm-up count before CHECK; unused when LAT=0.
    localparam logic [3:0] WARM_LAST = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_warm_cnt;
    logic [TAG_W-1:0] r_stamp;

    logic             r_pulse;
    logic [NCH-1:0]   r_sticky;
    logic             r_proto_err;
    logic [CNT_W-1:0] r_check_cnt;
    logic [CNT_W-1:0] r_mismatch_cnt;
    logic [NCH-1:0]   r_ff_vec;
    logic [TAG_W-1:0] r_ff_cycle;

    logic             w_exp_valid;
    logic [NCH-1:0]   w_exp_vec;
    logic             w_flush;
    logic             w_active;
    logic             w_cmp_fire;
    logic [NCH-1:0]   w_diff;
    logic             w_mis;
    logic             w_first;
    logic             w_proto_hit;
    logic             w_enter_check;

    // Valids are dropped whenever the monitor is disabled or cleared so
    // that stale golden entries never line up with fresh hardware beats.
    assign w_flush = !enable || clear;

    // ------------------------------------------------------------------
    // Golden delay line
    // ------------------------------------------------------------------
    if (LAT == 0) begin : g_nodly
        assign w_exp_valid = in_valid;
        assign w_exp_vec   = trusted_sw;
    end else begin : g_dly
        logic [LAT-1:0] r_dv;
        logic [NCH-1:0] r_dvec [LAT];

        // Shift golden {valid, verdict} pairs one stage per cycle.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_dv <= '0;
                for (int unsigned i = 0; i < LAT; i++) begin
                    r_dvec[i] <= '0;
                end
            end else begin
                if (w_flush) begin
                    r_dv <= '0;
                end else begin
                    r_dv[0] <= in_valid;
                    for (int unsigned i = 1; i < LAT; i++) begin
                        r_dv[i] <= r_dv[i-1];
                    end
                end
                r_dvec[0] <= trusted_sw;
                for (int unsigned i = 1; i < LAT; i++) begin
                    r_dvec[i] <= r_dvec[i-1];
                end
            end
        end

        assign w_exp_valid = r_dv[LAT-1];
        assign w_exp_vec   = r_dvec[LAT-1];
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: disable beats clear, clear beats compare.
    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else if (clear) begin
            w_state_nxt = (LAT == 0) ? ST_CHECK : ST_WARMUP;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_nxt = (LAT == 0) ? ST_CHECK : ST_WARMUP;
                ST_WARMUP: begin
                    if (r_warm_cnt == WARM_LAST) begin
                        w_state_nxt = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_mis) begin
                        w_state_nxt = ST_FAIL;
                    end
                end
                ST_FAIL:   w_state_nxt = ST_FAIL;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Compare qualification and output decode.
    always_comb begin
        state       = r_state;
        w_active    = (r_state == ST_CHECK) || (r_state == ST_FAIL);
        w_diff      = w_exp_vec ^ trusted_hw;
        w_cmp_fire  = w_active && w_exp_valid && hw_valid;
        w_mis       = w_cmp_fire && (w_diff != '0);
        w_first     = w_mis && (r_state == ST_CHECK);
        w_proto_hit = w_active && (w_exp_valid != hw_valid);
    end

    // Warm-up length counter; restarts on every entry into WARMUP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_warm_cnt <= '0;
        end else if ((r_state == ST_WARMUP) && (w_state_nxt == ST_WARMUP) && !clear) begin
            r_warm_cnt <= r_warm_cnt + 1'b1;
        end else begin
            r_warm_cnt <= '0;
        end
    end

    // A clear while already in CHECK (LAT=0) also counts as a fresh entry.
    assign w_enter_check = (w_state_nxt == ST_CHECK) &&
                           ((r_state != ST_CHECK) || clear);

    // Cycle stamp: zero on CHECK entry, saturating count in CHECK/FAIL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stamp <= '0;
        end else if (w_enter_check) begin
            r_stamp <= '0;
        end else if (w_active && (r_stamp != '1)) begin
            r_stamp <= r_stamp + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------

    // Counters, sticky flags, protocol flag and first-failure snapshot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pulse        <= 1'b0;
            r_sticky       <= '0;
            r_proto_err    <= 1'b0;
            r_check_cnt    <= '0;
            r_mismatch_cnt <= '0;
            r_ff_vec       <= '0;
            r_ff_cycle     <= '0;
        end else if (w_flush) begin
            r_pulse <= 1'b0;
            if (clear) begin
                r_sticky       <= '0;
                r_proto_err    <= 1'b0;
                r_check_cnt    <= '0;
                r_mismatch_cnt <= '0;
                r_ff_vec       <= '0;
                r_ff_cycle     <= '0;
            end
        end else begin
            r_pulse <= w_mis;
            if (w_cmp_fire && (r_check_cnt != '1)) begin
                r_check_cnt <= r_check_cnt + 1'b1;
            end
            if (w_mis) begin
                if (r_mismatch_cnt != '1) begin
                    r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
                end
                r_sticky <= r_sticky | w_diff;
            end
            if (w_first) begin
                r_ff_vec   <= w_diff;
                r_ff_cycle <= r_stamp;
            end
            if (w_proto_hit) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign mismatch_pulse   = r_pulse;
    assign mismatch_sticky  = r_sticky;
    assign proto_err        = r_proto_err;
    assign check_cnt        = r_check_cnt;
    assign mismatch_cnt     = r_mismatch_cnt;
    assign first_fail_vec   = r_ff_vec;
    assign first_fail_cycle = r_ff_cycle;

`ifdef REFLEX_EQUIV_ASSERT_EN
    // Report every failing channel of a compare that takes effect, and the
    // cycle in which the protocol flag first sets.
    always @(posedge clk) begin
        if (rst_n && enable && !clear) begin
            if (w_cmp_fire) begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    assert (!w_diff[i])
                        else $error("REFLEX-GATE mismatch ch=%0d @%0t", i, $time);
                end
            end
            assert (!(w_proto_hit && !r_proto_err))
                else $error("REFLEX-GATE proto_err @%0t", $time);
        end
    end
`endif

endmodule
